// File: rtl/nw_fill_controller_pkg.sv
// Shared types and constants for the Needleman-Wunsch fill sequencer.
package nw_fill_controller_pkg;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_READ     = 3'd2,
    ST_WAIT_MAX = 3'd3,
    ST_WRITE    = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } state_e;

  // Score word width and the most negative representable score.
  localparam int SCORE_W   = 9;
  localparam int SCORE_MIN = -256;

  // Gap penalty used when seeding row 0 and column 0.
  localparam int GAP_DEFAULT = -2;

endpackage

// File: rtl/nw_index_walker.sv
// Row-major (i,j) walker over cells (1,1)..(N,N) with a last-cell flag.
module nw_index_walker #(
  parameter int N  = 128,
  parameter int AW = $clog2(N + 1) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          load_first,
  input  logic          advance,
  output logic [AW-1:0] i,
  output logic [AW-1:0] j,
  output logic          last
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N);
  localparam logic [AW-1:0] ONE      = AW'(1);

  logic [AW-1:0] i_q, i_d;
  logic [AW-1:0] j_q, j_d;

  // Next index: clear on start, (1,1) after init, row-major step otherwise; never wraps past N.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clear) begin
      i_d = '0;
      j_d = '0;
    end else if (load_first) begin
      i_d = ONE;
      j_d = ONE;
    end else if (advance) begin
      if (j_q < LAST_IDX) begin
        j_d = j_q + ONE;
      end else if (i_q < LAST_IDX) begin
        i_d = i_q + ONE;
        j_d = ONE;
      end
    end
  end

  // Index registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i    = i_q;
  assign j    = j_q;
  assign last = (i_q == LAST_IDX) && (j_q == LAST_IDX);

endmodule

// File: rtl/nw_fill_controller.sv
// Needleman-Wunsch fill sequencer: seeds row/column 0, then walks every cell
// through read burst, max wait, write and index advance. Outputs are registered
// from the next state so they are glitch-free Moore signals.
module nw_fill_controller
  import nw_fill_controller_pkg::*;
#(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int GAP     = GAP_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      signal,
  input  logic                      hit,
  input  logic                      max_valid,
  output logic                      en_init,
  output logic                      en_read,
  output logic                      en_ins,
  output logic                      we,
  output logic                      change_index,
  output logic [BitAddr:0]          i,
  output logic [BitAddr:0]          j,
  output logic [BitAddr:0]          addr_init,
  output logic signed [SCORE_W-1:0] data_init,
  output logic                      busy,
  output logic                      done
);

  localparam int AW = BitAddr + 1;

  localparam logic [AW-1:0]             N_IDX     = AW'(N);
  localparam logic [AW-1:0]             ONE       = AW'(1);
  localparam logic signed [SCORE_W-1:0] MIN_SCORE = SCORE_W'(SCORE_MIN);
  localparam logic signed [SCORE_W:0]   MIN_EXT   = (SCORE_W + 1)'(SCORE_MIN);
  localparam logic signed [SCORE_W:0]   GAP_EXT   = (SCORE_W + 1)'(GAP);

  // Adds one gap penalty to the running init score, clamping at the score floor.
  function automatic logic signed [SCORE_W-1:0] sat_add_gap(
    input logic signed [SCORE_W-1:0] a
  );
    logic signed [SCORE_W:0] sum;
    sum = {a[SCORE_W-1], a} + GAP_EXT;
    if (sum < MIN_EXT) begin
      return MIN_SCORE;
    end
    return sum[SCORE_W-1:0];
  endfunction

  state_e                      state_q, state_d;
  logic [AW-1:0]               k_q, k_d;
  logic signed [SCORE_W-1:0]   acc_q, acc_d;

  logic                        en_init_q, en_init_d;
  logic                        en_read_q, en_read_d;
  logic                        en_ins_q, en_ins_d;
  logic                        we_q, we_d;
  logic                        change_index_q, change_index_d;
  logic [AW-1:0]               addr_init_q, addr_init_d;
  logic signed [SCORE_W-1:0]   data_init_q, data_init_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic                        wk_clear, wk_load, wk_adv, wk_last;
  logic [AW-1:0]               wk_i, wk_j;

  nw_index_walker #(
    .N  (N),
    .AW (AW)
  ) u_walker (
    .clk        (clk),
    .rst        (rst),
    .clear      (wk_clear),
    .load_first (wk_load),
    .advance    (wk_adv),
    .i          (wk_i),
    .j          (wk_j),
    .last       (wk_last)
  );

  // State, init counters and registered outputs; reset drops everything to zero at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      k_q            <= '0;
      acc_q          <= '0;
      en_init_q      <= 1'b0;
      en_read_q      <= 1'b0;
      en_ins_q       <= 1'b0;
      we_q           <= 1'b0;
      change_index_q <= 1'b0;
      addr_init_q    <= '0;
      data_init_q    <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      acc_q          <= acc_d;
      en_init_q      <= en_init_d;
      en_read_q      <= en_read_d;
      en_ins_q       <= en_ins_d;
      we_q           <= we_d;
      change_index_q <= change_index_d;
      addr_init_q    <= addr_init_d;
      data_init_q    <= data_init_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  // Next-state logic; abort overrides every other transition and blocks counter/index updates.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    wk_clear = 1'b0;
    wk_load  = 1'b0;
    wk_adv   = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_INIT;
            k_d      = '0;
            acc_d    = '0;
            wk_clear = 1'b1;
          end
        end
        ST_INIT: begin
          if (hit) begin
            if (k_q < N_IDX) begin
              k_d   = k_q + ONE;
              acc_d = sat_add_gap(acc_q);
            end else begin
              wk_load = 1'b1;
              state_d = ST_READ;
            end
          end
        end
        ST_READ: begin
          if (signal) state_d = ST_WAIT_MAX;
        end
        ST_WAIT_MAX: begin
          if (max_valid) state_d = ST_WRITE;
        end
        ST_WRITE: begin
          state_d = ST_NEXT;
        end
        ST_NEXT: begin
          if (wk_last) begin
            state_d = ST_DONE;
          end else begin
            wk_adv  = 1'b1;
            state_d = ST_READ;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so every output comes straight off a flop.
  always_comb begin
    en_init_d      = (state_d == ST_INIT);
    en_read_d      = (state_d == ST_READ);
    en_ins_d       = (state_d == ST_WRITE);
    we_d           = (state_d == ST_INIT) || (state_d == ST_WRITE);
    change_index_d = (state_d == ST_NEXT);
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
    addr_init_d    = '0;
    data_init_d    = '0;
    if (state_d == ST_INIT) begin
      addr_init_d = k_d;
      data_init_d = acc_d;
    end
  end

  assign en_init      = en_init_q;
  assign en_read      = en_read_q;
  assign en_ins       = en_ins_q;
  assign we           = we_q;
  assign change_index = change_index_q;
  assign addr_init    = addr_init_q;
  assign data_init    = data_init_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign i            = wk_i;
  assign j            = wk_j;

endmodule

// File: tb/tb_nw_fill_controller.sv
// Scoreboard bench for nw_fill_controller: a small N=4 instance for the fill
// sequence and an N=200 instance for init-score clamping.
module tb_nw_fill_controller;

  localparam int N1   = 4;
  localparam int AW1  = $clog2(N1 + 1) + 1;
  localparam int GAP1 = -2;
  localparam int N2   = 200;
  localparam int AW2  = $clog2(N2 + 1) + 1;

  typedef struct {
    int kind;  // 0 init write, 1 cell write, 2 index change, 3 done
    int a;
    int b;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, signal = 1'b0, hit = 1'b0, max_valid = 1'b0;
  logic en_init, en_read, en_ins, we, change_index, busy, done;
  logic [AW1-1:0] i, j, addr_init;
  logic signed [8:0] data_init;

  logic start2 = 1'b0, abort2 = 1'b0, signal2 = 1'b0, hit2 = 1'b0, max_valid2 = 1'b0;
  logic en_init2, en_read2, en_ins2, we2, change_index2, busy2, done2;
  logic [AW2-1:0] i2, j2, addr_init2;
  logic signed [8:0] data_init2;

  int nvec = 0;
  int nerr = 0;
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  nw_fill_controller #(.N(N1), .GAP(GAP1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .signal(signal),
    .hit(hit), .max_valid(max_valid), .en_init(en_init), .en_read(en_read),
    .en_ins(en_ins), .we(we), .change_index(change_index), .i(i), .j(j),
    .addr_init(addr_init), .data_init(data_init), .busy(busy), .done(done)
  );

  nw_fill_controller #(.N(N2), .GAP(-2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .signal(signal2),
    .hit(hit2), .max_valid(max_valid2), .en_init(en_init2), .en_read(en_read2),
    .en_ins(en_ins2), .we(we2), .change_index(change_index2), .i(i2), .j(j2),
    .addr_init(addr_init2), .data_init(data_init2), .busy(busy2), .done(done2)
  );

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp_score(input int v);
    return (v < -256) ? -256 : v;
  endfunction

  task automatic push1(input int kind, input int a, input int b);
    exp_t e;
    e.kind = kind; e.a = a; e.b = b;
    q1.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the N=4 instance: every handshake/pulse pops one expected event.
  exp_t m1;
  int   k1, a1, b1;
  bit   ev1;
  always @(negedge clk) begin
    if (rst) begin
      ev1 = 1'b1;
      if (we && en_init && hit)  begin k1 = 0; a1 = int'(addr_init); b1 = int'(data_init); end
      else if (we && en_ins)     begin k1 = 1; a1 = int'(i); b1 = int'(j); end
      else if (change_index)     begin k1 = 2; a1 = int'(i); b1 = int'(j); end
      else if (done)             begin k1 = 3; a1 = int'(i); b1 = int'(j); end
      else ev1 = 1'b0;
      if (ev1) begin
        nvec++;
        if (q1.size() == 0) begin
          nerr++;
          $display("FAIL sb1 unexpected event: got kind=%0d a=%0d b=%0d, required none", k1, a1, b1);
        end else begin
          m1 = q1.pop_front();
          if (m1.kind != k1 || m1.a != a1 || m1.b != b1) begin
            nerr++;
            $display("FAIL sb1 event: got kind=%0d a=%0d b=%0d, required kind=%0d a=%0d b=%0d",
                     k1, a1, b1, m1.kind, m1.a, m1.b);
          end
        end
      end
    end
  end

  // Monitor for the N=200 instance: init write handshakes only.
  exp_t m2;
  always @(negedge clk) begin
    if (rst && we2 && en_init2 && hit2) begin
      nvec++;
      if (q2.size() == 0) begin
        nerr++;
        $display("FAIL sb2 unexpected init write: got addr=%0d data=%0d", int'(addr_init2), int'(data_init2));
      end else begin
        m2 = q2.pop_front();
        if (m2.a != int'(addr_init2) || m2.b != int'(data_init2)) begin
          nerr++;
          $display("FAIL sb2 init write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                   int'(addr_init2), int'(data_init2), m2.a, m2.b);
        end
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Init phase on the N=4 instance with `gap` idle cycles before each hit.
  task automatic run_init(input int gap);
    for (int k = 0; k <= N1; k++) push1(0, k, clamp_score(k * GAP1));
    for (int k = 0; k <= N1; k++) begin
      repeat (gap) step();
      hit = 1'b1;
      step();
      hit = 1'b0;
    end
  endtask

  task automatic wait_read(input string tag);
    int n;
    n = 0;
    while (!en_read && n < 50) begin
      step();
      n++;
    end
    if (!en_read) begin
      nvec++;
      nerr++;
      $display("FAIL %s: en_read never rose within 50 cycles, got 0 required 1", tag);
    end
  endtask

  // One cell: read burst of t_read cycles, then max after t_max cycles in WAIT_MAX.
  task automatic do_cell(input int t_read, input int t_max, input bit both,
                         input bit stall_chk, input int ei, input int ej);
    push1(1, ei, ej);
    push1(2, ei, ej);
    wait_read("cell_read");
    repeat (t_read - 1) step();
    signal = 1'b1;
    if (both) max_valid = 1'b1;
    step();
    signal = 1'b0;
    max_valid = 1'b0;
    if (both) check("simul_no_write", int'({we, en_ins}), 0);
    for (int c = 0; c < t_max - 1; c++) begin
      if (stall_chk) begin
        check("stall_ij", int'(i) * 16 + int'(j), ei * 16 + ej);
        check("stall_en", int'({en_init, en_read, en_ins, we, change_index}), 0);
      end
      step();
    end
    max_valid = 1'b1;
    step();
    max_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, sampled before any clock edge.
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_en", int'({en_init, en_read, en_ins, we, change_index, done}), 0);
    check("rst_ij", int'(i) * 16 + int'(j), 0);
    check("rst_init", int'(addr_init) * 1000 + int'(data_init), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();

    // Reset asserted mid-READ clears outputs asynchronously.
    do_start();
    run_init(1);
    wait_read("rst_mid");
    check("init_to_read_ij", int'(i) * 16 + int'(j), 1 * 16 + 1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_en", int'({en_init, en_read, en_ins, we, change_index, done, busy}), 0);
    check("async_rst_ij", int'(i) * 16 + int'(j), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    check("post_rst_idle", int'({busy, en_init, en_read}), 0);

    // Full fill with a simultaneous signal/max at (1,2) and a long stall at (2,3).
    do_start();
    run_init(1);
    for (int r = 1; r <= N1; r++) begin
      for (int c = 1; c <= N1; c++) begin
        if (r == 1 && c == 2)      do_cell(3, 2, 1'b1, 1'b0, r, c);
        else if (r == 2 && c == 3) do_cell(3, 21, 1'b0, 1'b1, r, c);
        else                       do_cell(3, 1, 1'b0, 1'b0, r, c);
      end
    end
    push1(3, N1, N1);
    begin
      int n;
      n = 0;
      while (busy && n < 20) begin
        step();
        n++;
      end
    end
    check("fill_idle_busy", int'(busy), 0);
    check("fill_idle_en", int'({en_init, en_read, en_ins, we, change_index, done}), 0);
    check("fill_hold_ij", int'(i) * 16 + int'(j), N1 * 16 + N1);

    // Abort in WAIT_MAX at (3,1), then restart from k=0.
    do_start();
    run_init(0);
    for (int r = 1; r <= 2; r++)
      for (int c = 1; c <= N1; c++) do_cell(2, 1, 1'b0, 1'b0, r, c);
    wait_read("abort_read");
    check("abort_cell_ij", int'(i) * 16 + int'(j), 3 * 16 + 1);
    signal = 1'b1;
    step();
    signal = 1'b0;
    check("abort_in_wait", int'({en_read, en_ins, we}), 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_en", int'({en_init, en_read, en_ins, we, change_index, done}), 0);
    repeat (3) step();
    do_start();
    check("restart_init", int'({en_init, we}), 3);
    check("restart_k0", int'(addr_init) * 1000 + int'(data_init), 0);
    run_init(0);
    wait_read("restart_read");
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_read_busy", int'(busy), 0);

    // Clamp on the N=200 instance; a start pulse mid-init must be ignored.
    for (int k = 0; k <= N2; k++) begin
      exp_t e;
      e.kind = 0; e.a = k; e.b = clamp_score(k * -2);
      q2.push_back(e);
    end
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    hit2 = 1'b1;
    for (int k = 0; k <= N2; k++) begin
      if (k == 50) start2 = 1'b1;
      step();
      start2 = 1'b0;
    end
    hit2 = 1'b0;
    check("clamp_to_read", int'(en_read2), 1);
    check("clamp_ij", int'(i2) * 256 + int'(j2), 1 * 256 + 1);
    abort2 = 1'b1;
    step();
    abort2 = 1'b0;
    check("clamp_abort_busy", int'(busy2), 0);

    repeat (3) step();
    check("sb1_drained", q1.size(), 0);
    check("sb2_drained", q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/nw_fill_controller.md
Name: nw_fill_controller

Overview:
Sequencer that drives the score-matrix manager through a full Needleman-Wunsch fill. It first initialises row 0 and column 0 with gap penalties. It then walks cells (1,1)..(N,N) in row-major order, issuing a read burst, a wait for the max/compare datapath, a write and an index advance for each cell. It sits between the top-level start/done interface and the score manager's en_init/en_read/en_ins/we/change_index/i/j/addr_init/data_init inputs.

Parameters:
N, 128, sequence length; matrix is (N+1)x(N+1)
BitAddr, $clog2(N+1), index width minus one; i/j/addr_init are BitAddr+1 bits
GAP, -2, signed gap penalty used for row/column initialisation

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  begin fill; sampled only in IDLE
abort  input  1  synchronous abort to IDLE from any state
signal  input  1  score manager: diag/up/left read burst complete
hit  input  1  score manager: init write pair for current addr_init complete
max_valid  input  1  max datapath result valid for current cell
en_init  output  1  init-phase enable
en_read  output  1  read-burst enable
en_ins  output  1  cell-insert enable
we  output  1  RAM write enable
change_index  output  1  one-cycle pulse: cell index advanced
i  output  BitAddr+1  current row index
j  output  BitAddr+1  current column index
addr_init  output  BitAddr+1  init index k
data_init  output  9 signed  k*GAP, clamped to -256
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on fill completion

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including i, j, addr_init and data_init.
- All outputs are registered (Moore) and depend on state and counters only.
- IDLE: outputs 0. start=1 -> INIT with k=0, data_init=0. start in any other state is ignored.
- INIT: en_init=1, we=1, addr_init=k, data_init=k*GAP.
  - hit=1 and k<N: k<=k+1; data_init<=data_init+GAP, saturating at -256.
  - hit=1 and k==N: i<=1, j<=1 -> READ.
- READ: en_read=1, others 0. Stays in READ until signal=1, then -> WAIT_MAX. en_read is low from the next cycle.
- WAIT_MAX: all enables 0; i/j held. max_valid=1 -> WRITE. max_valid seen outside WAIT_MAX is ignored.
- WRITE: en_ins=1, we=1 for exactly one cycle -> NEXT.
- NEXT: change_index=1 for exactly one cycle.
  - j<N: j<=j+1 -> READ.
  - j==N and i<N: i<=i+1, j<=1 -> READ.
  - i==N and j==N -> DONE.
- DONE: done=1, busy=1 for one cycle -> IDLE. i/j keep N,N until the next start.
- abort=1: -> IDLE next cycle from any state; enables and change_index drop to 0. abort has priority over every other transition.
- Reset mid-operation: immediate return to the reset values; no partial write is completed.
- Simultaneous signal and max_valid in READ: only signal is acted on; max_valid must be re-presented in WAIT_MAX.
- Per-cell latency: t_read + t_max + 2 cycles. t_read counts from READ entry to signal; t_max counts from WAIT_MAX entry to max_valid.
- Width rules:
  - i, j, k are unsigned and never exceed N; no wrap-around.
  - data_init is 9-bit two's complement, clamped at -256 when N*|GAP| > 256.

Decomposition:
- Shared package holds:
  - state enum IDLE/INIT/READ/WAIT_MAX/WRITE/NEXT/DONE (3-bit encoding);
  - SCORE_W=9 and SCORE_MIN=-256;
  - default GAP.
- One natural sub-module: nw_index_walker. It owns i/j, the row-major advance, and the last-cell flag (i==N && j==N).
- The controller FSM instantiates nw_index_walker and keeps the init counter k and the data_init accumulator.

Test Plan:
- Reset: rst=0 mid-READ with N=4 -> all outputs 0 asynchronously; state IDLE after release; busy=0.
- Init, N=4, GAP=-2, hit every 2nd cycle -> addr_init 0..4 with data_init 0,-2,-4,-6,-8. Each value is held until hit; then READ with i=1, j=1.
- Full fill, N=4, signal 3 cycles after en_read, max_valid 1 cycle after WAIT_MAX -> 16 WRITE pulses and 16 change_index pulses. (i,j) sequence is (1,1),(1,2)..(4,4); done pulses once, then IDLE.
- Stalls: max_valid withheld 20 cycles at (2,3) -> i/j stable, en_* all 0, no write; resumes normally afterwards.
- Abort in WAIT_MAX at (3,1) -> IDLE next cycle, no done pulse. A new start restarts from INIT with k=0.
- Clamp: N=200, GAP=-2 -> data_init saturates at -256 from k=128 onward; start pulsed during the fill is ignored.
